inst_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction cache. It owns the PC and presents it to the icache read port each cycle. On a hit it issues the instruction to decode. On a miss it reads the 32-bit word byte-serially from the memory controller, assembles it little-endian, writes it into the icache, and issues it to decode. Branch redirects flush the stage, and stall holds it.

---
 rtl/inst_fetch.sv | 150 +++++++++++++++
 tb/tb_inst_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues icache hits to decode and
// refills misses from a byte-serial memory port, assembling words little-endian.
module inst_fetch #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic [ADDR_W-1:0] ic_raddr_o,
  input  logic              ic_hit_i,
  input  logic [31:0]       ic_inst_i,
  output logic              ic_we_o,
  output logic [ADDR_W-1:0] ic_waddr_o,
  output logic [31:0]       ic_winst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [7:0]        mem_data_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o
);

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_FETCH  = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_cnt;
  logic [31:0]       r_buf;
  logic              r_if_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [31:0]       r_if_inst;

  state_t            w_state_next;
  logic [ADDR_W-1:0] w_pc_next;
  logic [1:0]        w_cnt_next;
  logic [31:0]       w_buf_next;
  logic              w_if_valid_next;
  logic [ADDR_W-1:0] w_if_pc_next;
  logic [31:0]       w_if_inst_next;

  logic              w_fetch;
  logic              w_write;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_target;

  assign w_fetch    = (r_state == S_FETCH);
  assign w_write    = (r_state == S_WRITE);
  assign w_pc_plus4 = r_pc + {{(ADDR_W-3){1'b0}}, 3'd4};
  // Masking (rather than slicing) keeps every target bit referenced.
  assign w_target   = branch_target_i & ~{{(ADDR_W-2){1'b0}}, 2'b11};

  assign ic_raddr_o = r_pc;
  assign mem_req_o  = w_fetch;
  assign mem_addr_o = w_fetch ? (r_pc + {{(ADDR_W-2){1'b0}}, r_cnt}) : '0;
  assign ic_we_o    = w_write;
  assign ic_waddr_o = w_write ? r_pc : '0;
  assign ic_winst_o = w_write ? r_buf : '0;
  assign if_valid_o = r_if_valid;
  assign if_pc_o    = r_if_pc;
  assign if_inst_o  = r_if_inst;

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_cnt_next      = r_cnt;
    w_buf_next      = r_buf;
    w_if_valid_next = r_if_valid;
    w_if_pc_next    = r_if_pc;
    w_if_inst_next  = r_if_inst;
    if (rdy) begin
      if (branch_i) begin
        w_pc_next       = w_target;
        w_state_next    = S_LOOKUP;
        w_cnt_next      = 2'd0;
        w_if_valid_next = 1'b0;
      end else begin
        case (r_state)
          S_LOOKUP: begin
            if (ic_hit_i) begin
              if (!stall_i) begin
                w_if_valid_next = 1'b1;
                w_if_pc_next    = r_pc;
                w_if_inst_next  = ic_inst_i;
                w_pc_next       = w_pc_plus4;
              end
            end else begin
              w_state_next = S_FETCH;
              w_cnt_next   = 2'd0;
              if (!stall_i) w_if_valid_next = 1'b0;
            end
          end
          S_FETCH: begin
            // Stall does not pause the refill; it only freezes the issue regs.
            if (!stall_i) w_if_valid_next = 1'b0;
            if (mem_valid_i) begin
              case (r_cnt)
                2'd0:    w_buf_next[7:0]   = mem_data_i;
                2'd1:    w_buf_next[15:8]  = mem_data_i;
                2'd2:    w_buf_next[23:16] = mem_data_i;
                default: w_buf_next[31:24] = mem_data_i;
              endcase
              w_cnt_next = r_cnt + 2'd1;
              if (r_cnt == 2'd3) w_state_next = S_WRITE;
            end
          end
          S_WRITE: begin
            w_state_next = S_LOOKUP;
            if (!stall_i) begin
              w_if_valid_next = 1'b1;
              w_if_pc_next    = r_pc;
              w_if_inst_next  = r_buf;
              w_pc_next       = w_pc_plus4;
            end
          end
          default: w_state_next = S_LOOKUP;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_LOOKUP;
      r_pc       <= RESET_PC;
      r_cnt      <= 2'd0;
      r_buf      <= 32'd0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_cnt      <= w_cnt_next;
      r_buf      <= w_buf_next;
      r_if_valid <= w_if_valid_next;
      r_if_pc    <= w_if_pc_next;
      r_if_inst  <= w_if_inst_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vectors for the corner cases, then random
// traffic checked against a program-order / memory-image reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, stall_i, branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] ic_raddr_o;
  logic        ic_hit_i;
  logic [31:0] ic_inst_i;
  logic        ic_we_o;
  logic [31:0] ic_waddr_o, ic_winst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_valid_i;
  logic [7:0]  mem_data_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o, if_inst_o;

  int checks = 0;
  int failures = 0;

  inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .ic_raddr_o(ic_raddr_o),
    .ic_hit_i(ic_hit_i), .ic_inst_i(ic_inst_i), .ic_we_o(ic_we_o),
    .ic_waddr_o(ic_waddr_o), .ic_winst_o(ic_winst_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory image seen by the random phase.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  typedef struct packed {
    logic        hit;
    logic [31:0] inst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_raddr;
  } vec_t;

  typedef struct packed {
    logic        rdy;
    logic        valid;
    logic [7:0]  data;
    logic [31:0] exp_addr;
  } gap_t;

  vec_t        tbl [9];
  gap_t        gaps [8];
  logic [7:0]  cold_bytes [4];
  logic [7:0]  wb_bytes [4];
  logic [31:0] cache [logic [31:0]];

  // Reference-model state for the random phase.
  logic [31:0] exp_pc, m_pc, m_inst;
  logic        m_valid;
  logic        p_rdy, p_stall, p_br;
  logic [31:0] p_tgt;
  int          last_prog, n_issue, n_write;

  initial begin
    tbl[0] = '{1'b1, 32'hA, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,  32'hA, 32'h8};
    tbl[1] = '{1'b1, 32'hB, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,  32'hB, 32'hC};
    tbl[2] = '{1'b1, 32'hC, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,  32'hB, 32'hC};
    tbl[3] = '{1'b1, 32'hC, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,  32'hB, 32'hC};
    tbl[4] = '{1'b1, 32'hC, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,  32'hB, 32'hC};
    tbl[5] = '{1'b1, 32'hC, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,  32'hC, 32'h10};
    tbl[6] = '{1'b1, 32'hD, 1'b0, 1'b1, 32'h103, 1'b0, 32'hC,  32'hC, 32'h100};
    tbl[7] = '{1'b1, 32'hE, 1'b1, 1'b1, 32'h20,  1'b0, 32'hC,  32'hC, 32'h20};
    tbl[8] = '{1'b1, 32'hE, 1'b0, 1'b0, 32'h0,   1'b1, 32'h20, 32'hE, 32'h24};
    gaps[0] = '{1'b1, 1'b1, 8'h78, 32'h100};
    gaps[1] = '{1'b1, 1'b0, 8'h00, 32'h101};
    gaps[2] = '{1'b1, 1'b0, 8'h00, 32'h101};
    gaps[3] = '{1'b1, 1'b1, 8'h56, 32'h101};
    gaps[4] = '{1'b0, 1'b1, 8'hEE, 32'h102};
    gaps[5] = '{1'b1, 1'b1, 8'h34, 32'h102};
    gaps[6] = '{1'b1, 1'b0, 8'h00, 32'h103};
    gaps[7] = '{1'b1, 1'b1, 8'h12, 32'h103};
    cold_bytes = '{8'h13, 8'h05, 8'h10, 8'h00};
    wb_bytes   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    rst = 1'b0; rdy = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'h0;
    ic_hit_i = 1'b0; ic_inst_i = 32'h0; mem_valid_i = 1'b0; mem_data_i = 8'h0;

    // Reset
    step(); step();
    rst = 1'b1;
    #1;
    chk("reset_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("reset_if_pc", if_pc_o, 32'h0);
    chk("reset_if_inst", if_inst_o, 32'h0);
    chk("reset_raddr", ic_raddr_o, 32'h0);
    chk("reset_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("reset_ic_we", {31'b0, ic_we_o}, 32'd0);

    // Cold miss at pc 0
    step();
    for (int i = 0; i < 4; i++) begin
      mem_valid_i = 1'b1; mem_data_i = cold_bytes[i];
      #1;
      chk("cold_mem_req", {31'b0, mem_req_o}, 32'd1);
      chk("cold_mem_addr", mem_addr_o, i);
      step();
    end
    mem_valid_i = 1'b0;
    #1;
    chk("cold_we", {31'b0, ic_we_o}, 32'd1);
    chk("cold_waddr", ic_waddr_o, 32'h0);
    chk("cold_winst", ic_winst_o, 32'h00100513);
    chk("cold_write_no_req", {31'b0, mem_req_o}, 32'd0);
    chk("cold_write_no_issue", {31'b0, if_valid_o}, 32'd0);
    step();
    chk("cold_issue_valid", {31'b0, if_valid_o}, 32'd1);
    chk("cold_issue_pc", if_pc_o, 32'h0);
    chk("cold_issue_inst", if_inst_o, 32'h00100513);
    chk("cold_next_raddr", ic_raddr_o, 32'h4);
    chk("cold_we_pulse", {31'b0, ic_we_o}, 32'd0);

    // Hit / stall / branch vectors
    for (int i = 0; i < 9; i++) begin
      ic_hit_i = tbl[i].hit; ic_inst_i = tbl[i].inst; stall_i = tbl[i].stall;
      branch_i = tbl[i].br; branch_target_i = tbl[i].tgt;
      step();
      chk($sformatf("vec%0d_valid", i), {31'b0, if_valid_o}, {31'b0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_pc", i), if_pc_o, tbl[i].exp_pc);
      chk($sformatf("vec%0d_inst", i), if_inst_o, tbl[i].exp_inst);
      chk($sformatf("vec%0d_raddr", i), ic_raddr_o, tbl[i].exp_raddr);
    end
    branch_i = 1'b0; stall_i = 1'b0;

    // Branch mid-fetch at 0x24 after two bytes
    ic_hit_i = 1'b0;
    step();
    mem_valid_i = 1'b1; mem_data_i = 8'h11; #1;
    chk("bmf_addr0", mem_addr_o, 32'h24);
    step();
    mem_data_i = 8'h22; #1;
    chk("bmf_addr1", mem_addr_o, 32'h25);
    step();
    branch_i = 1'b1; branch_target_i = 32'h103; mem_data_i = 8'h33;
    step();
    branch_i = 1'b0; mem_valid_i = 1'b0;
    #1;
    chk("bmf_raddr", ic_raddr_o, 32'h100);
    chk("bmf_no_we", {31'b0, ic_we_o}, 32'd0);
    chk("bmf_no_req", {31'b0, mem_req_o}, 32'd0);
    chk("bmf_valid", {31'b0, if_valid_o}, 32'd0);

    // Gaps and a rdy freeze during the refill of 0x100
    step();
    for (int i = 0; i < 8; i++) begin
      rdy = gaps[i].rdy; mem_valid_i = gaps[i].valid; mem_data_i = gaps[i].data;
      #1;
      chk($sformatf("gap%0d_addr", i), mem_addr_o, gaps[i].exp_addr);
      step();
    end
    rdy = 1'b1; mem_valid_i = 1'b0;
    #1;
    chk("gap_we", {31'b0, ic_we_o}, 32'd1);
    chk("gap_waddr", ic_waddr_o, 32'h100);
    chk("gap_winst", ic_winst_o, 32'h12345678);
    step();
    chk("gap_issue_valid", {31'b0, if_valid_o}, 32'd1);
    chk("gap_issue_pc", if_pc_o, 32'h100);
    chk("gap_issue_inst", if_inst_o, 32'h12345678);
    chk("gap_raddr", ic_raddr_o, 32'h104);

    // Branch during WRITE: write still happens, nothing issues
    step();
    for (int i = 0; i < 4; i++) begin
      mem_valid_i = 1'b1; mem_data_i = wb_bytes[i];
      step();
    end
    mem_valid_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h200;
    #1;
    chk("bw_we", {31'b0, ic_we_o}, 32'd1);
    chk("bw_waddr", ic_waddr_o, 32'h104);
    chk("bw_winst", ic_winst_o, 32'hD4C3B2A1);
    step();
    branch_i = 1'b0;
    chk("bw_valid", {31'b0, if_valid_o}, 32'd0);
    chk("bw_raddr", ic_raddr_o, 32'h200);
    chk("bw_if_pc_held", if_pc_o, 32'h100);
    chk("bw_we_off", {31'b0, ic_we_o}, 32'd0);

    // Random phase
    rst = 1'b0; step(); rst = 1'b1;
    cache.delete();
    for (int i = 0; i < 16; i++) cache[i * 8] = mem_word(i * 8);
    exp_pc = 32'h0; m_valid = 1'b0; m_pc = 32'h0; m_inst = 32'h0;
    last_prog = 0; n_issue = 0; n_write = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy = ($urandom_range(0, 9) != 0);
      stall_i = ($urandom_range(0, 3) == 0);
      branch_i = ($urandom_range(0, 19) == 0);
      branch_target_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                   : 32'($urandom_range(0, 255));
      mem_valid_i = ($urandom_range(0, 9) < 6);
      #1;
      mem_data_i = mem_byte(mem_addr_o);
      ic_hit_i = cache.exists(ic_raddr_o) ? 1'b1 : 1'b0;
      ic_inst_i = ic_hit_i ? cache[ic_raddr_o] : $urandom;
      #1;
      if (mem_req_o) chk("rnd_mem_addr_word", {2'b0, mem_addr_o[31:2]}, {2'b0, exp_pc[31:2]});
      if (ic_we_o) begin
        chk("rnd_waddr", ic_waddr_o, exp_pc);
        chk("rnd_winst", ic_winst_o, mem_word(exp_pc));
        chk("rnd_we_excl_req", {31'b0, mem_req_o}, 32'd0);
        cache[exp_pc] = mem_word(exp_pc);
        n_write++;
      end else begin
        chk("rnd_wfields_zero", ic_waddr_o | ic_winst_o, 32'h0);
      end
      p_rdy = rdy; p_stall = stall_i; p_br = branch_i; p_tgt = branch_target_i;
      step();
      if (!p_rdy || (p_stall && !p_br)) begin
        chk("rnd_hold_valid", {31'b0, if_valid_o}, {31'b0, m_valid});
        chk("rnd_hold_pc", if_pc_o, m_pc);
        chk("rnd_hold_inst", if_inst_o, m_inst);
      end else if (p_br) begin
        exp_pc = p_tgt & 32'hFFFF_FFFC;
        m_valid = 1'b0;
        last_prog = cyc;
        chk("rnd_branch_valid", {31'b0, if_valid_o}, 32'd0);
      end else if (if_valid_o) begin
        chk("rnd_issue_pc", if_pc_o, exp_pc);
        chk("rnd_issue_inst", if_inst_o, mem_word(exp_pc));
        m_valid = 1'b1; m_pc = exp_pc; m_inst = mem_word(exp_pc);
        exp_pc = exp_pc + 32'd4;
        last_prog = cyc;
        n_issue++;
      end else begin
        m_valid = 1'b0;
      end
      chk("rnd_raddr", ic_raddr_o, exp_pc);
      if (cyc - last_prog > 400) begin
        chk("rnd_progress", 32'(cyc - last_prog), 32'd400);
        break;
      end
    end
    rdy = 1'b1; stall_i = 1'b0; branch_i = 1'b0;
    chk("rnd_issue_count_ok", {31'b0, (n_issue > 50)}, 32'd1);
    chk("rnd_write_count_ok", {31'b0, (n_write > 5)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
